// File: rtl/seven_seg_count_display_if.sv
// Display-side bundle: binary count in, multiplexed anode/cathode drive and load pulse out.
interface seven_seg_count_display_if;
  logic [15:0] count;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        bcd_valid;

  modport master (output count, input anode, cathode, dp, bcd_valid);
  modport slave  (input count, output anode, cathode, dp, bcd_valid);
endinterface

// File: rtl/seven_seg_count_display.sv
// Binary count -> clamped BCD (sequential double-dabble) -> 4-digit multiplexed seven-segment drive.
// Display loads 17 clocks after capture; no backpressure, count is sampled only while IDLE.
module seven_seg_count_display #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic clock_100Mhz,
  input  logic reset,
  seven_seg_count_display_if.slave bus
);
  localparam int unsigned RW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [15:0]   last_val_q, last_val_d;
  logic [15:0]   src_q, src_d;
  logic [15:0]   bcd_q, bcd_d, bcd_adj;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   digits_q, digits_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_sel_q, digit_sel_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;
  logic          bcd_valid_q, bcd_valid_d;
  logic [3:0]    cur_digit;
  logic          blank;
  logic          refresh_tc;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    last_val_d  = last_val_q;
    src_d       = src_q;
    bcd_d       = bcd_q;
    bcd_adj     = bcd_q;
    bit_cnt_d   = bit_cnt_q;
    digits_d    = digits_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        // last_val keeps the unclamped count so distinct overrange values still retrigger
        if (bus.count != last_val_q) begin
          src_d      = (bus.count > 16'd9999) ? 16'd9999 : bus.count;
          last_val_d = bus.count;
          bcd_d      = '0;
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        for (int i = 0; i < 4; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d     = {bcd_adj[14:0], src_q[15]};
        src_d     = {src_q[14:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        digits_d    = bcd_q;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refresh_tc  = (refresh_q == RW'(REFRESH_DIV - 1));
    refresh_d   = refresh_tc ? '0 : refresh_q + RW'(1);
    digit_sel_d = refresh_tc ? digit_sel_q + 2'd1 : digit_sel_q;
    cur_digit   = digits_q[4*digit_sel_q +: 4];
    blank       = 1'b0;
    if (BLANK_LEADING) begin
      case (digit_sel_q)
        2'd3:    blank = (digits_q[15:12] == 4'd0);
        2'd2:    blank = (digits_q[15:8] == 8'd0);
        2'd1:    blank = (digits_q[15:4] == 12'd0);
        default: blank = 1'b0;
      endcase
    end
    anode_d   = ~(4'b0001 << digit_sel_q);
    cathode_d = blank ? 7'b1111111 : seg7(cur_digit);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_q     <= IDLE;
      last_val_q  <= '0;
      src_q       <= '0;
      bcd_q       <= '0;
      bit_cnt_q   <= '0;
      digits_q    <= '0;
      refresh_q   <= '0;
      digit_sel_q <= '0;
      anode_q     <= 4'hF;
      cathode_q   <= 7'h7F;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_val_q  <= last_val_d;
      src_q       <= src_d;
      bcd_q       <= bcd_d;
      bit_cnt_q   <= bit_cnt_d;
      digits_q    <= digits_d;
      refresh_q   <= refresh_d;
      digit_sel_q <= digit_sel_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign bus.anode     = anode_q;
  assign bus.cathode   = cathode_q;
  assign bus.dp        = 1'b1;
  assign bus.bcd_valid = bcd_valid_q;
endmodule

// File: tb/tb_seven_seg_count_display.sv
// Bench for seven_seg_count_display: directed counts, scoreboard of expected load cycle and frame contents.
module tb_seven_seg_count_display;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SB = 7'b1111111;

  typedef struct packed {
    logic [31:0]     cyc;
    logic [3:0][6:0] c1;
    logic [3:0][6:0] c0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_busy = 1'b0;
  exp_t sb_q[$];

  seven_seg_count_display_if cv1 ();
  seven_seg_count_display_if cv0 ();

  seven_seg_count_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut1 (
    .clock_100Mhz(clk), .reset(rst), .bus(cv1));
  seven_seg_count_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut0 (
    .clock_100Mhz(clk), .reset(rst), .bus(cv0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] c, input logic [6:0] a3, a2, a1, a0,
                              input logic [6:0] b3, b2, b1, b0);
    exp_t e;
    e.cyc = c;
    e.c1  = {a3, a2, a1, a0};
    e.c0  = {b3, b2, b1, b0};
    return e;
  endfunction

  task automatic set_count(input logic [15:0] v);
    cv1.count = v;
    cv0.count = v;
  endtask

  // Samples 16 consecutive cycles starting at the current negedge: one full frame at REFRESH_DIV=4.
  task automatic frame_checks(input exp_t e);
    logic [3:0][6:0] g1, g0;
    int hits[4];
    int k;
    g1 = '1;
    g0 = '1;
    for (int j = 0; j < 4; j++) hits[j] = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      case (cv1.anode)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      if (k >= 0) begin
        g1[k] = cv1.cathode;
        g0[k] = cv0.cathode;
        hits[k]++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      check($sformatf("slot_len_d%0d", j), hits[j], 4);
      check($sformatf("cathode_blank_d%0d", j), g1[j], e.c1[j]);
      check($sformatf("cathode_noblank_d%0d", j), g0[j], e.c0[j]);
    end
    check("dp_off", {cv1.dp, cv0.dp}, 2'b11);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || mon_busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: pending=%0d busy=%0d, required 0 and 0", sb_q.size(), mon_busy);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every bcd_valid pulse pops one expectation and checks timing and the next frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cv1.bcd_valid === 1'b1 || cv0.bcd_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bcd_valid: pulse at cycle %0d, required none", cyc);
        end else begin
          mon_busy = 1'b1;
          e = sb_q.pop_front();
          check("valid_cycle", cyc, e.cyc);
          check("valid_both", {cv1.bcd_valid, cv0.bcd_valid}, 2'b11);
          @(negedge clk);
          check("valid_one_cycle", {cv1.bcd_valid, cv0.bcd_valid}, 2'b00);
          frame_checks(e);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst = 1'b1;
    set_count(16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_anode", {cv1.anode, cv0.anode}, 8'hFF);
    check("reset_cathode", {cv1.cathode, cv0.cathode}, 14'h3FFF);
    check("reset_dp", {cv1.dp, cv0.dp}, 2'b11);
    check("reset_valid", {cv1.bcd_valid, cv0.bcd_valid}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_anode", cv1.anode, 4'b1110);
    check("post_reset_cathode", cv1.cathode, S0);
    frame_checks(mk(0, SB, SB, SB, S0, S0, S0, S0, S0));
    repeat (3) @(negedge clk);

    c = cyc; set_count(16'd1234);
    sb_q.push_back(mk(c + 18, S1, S2, S3, S4, S1, S2, S3, S4));
    wait_idle(80);

    c = cyc; set_count(16'd12000);
    sb_q.push_back(mk(c + 18, S9, S9, S9, S9, S9, S9, S9, S9));
    wait_idle(80);
    c = cyc; set_count(16'd65535);
    sb_q.push_back(mk(c + 18, S9, S9, S9, S9, S9, S9, S9, S9));
    wait_idle(80);

    c = cyc; set_count(16'd7);
    sb_q.push_back(mk(c + 18, SB, SB, SB, S7, S0, S0, S0, S7));
    wait_idle(80);

    // 5678 arrives mid-SHIFT: first result must be the untouched 1234, then a chained conversion.
    c = cyc; set_count(16'd1234);
    sb_q.push_back(mk(c + 18, S1, S2, S3, S4, S1, S2, S3, S4));
    repeat (6) @(negedge clk);
    set_count(16'd5678);
    sb_q.push_back(mk(c + 36, S5, S6, S7, S8, S5, S6, S7, S8));
    wait_idle(120);

    c = cyc; set_count(16'd4321);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midshift_reset_anode", {cv1.anode, cv0.anode}, 8'hFF);
    check("midshift_reset_cathode", {cv1.cathode, cv0.cathode}, 14'h3FFF);
    check("midshift_reset_valid", {cv1.bcd_valid, cv0.bcd_valid}, 2'b00);
    rst = 1'b0;
    c = cyc;
    sb_q.push_back(mk(c + 18, S4, S3, S2, S1, S4, S3, S2, S1));
    wait_idle(80);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
